core_run_ctrl: RTL and testbench

//  Host-side run sequencer sitting directly upstream of the processor top level.
//  It holds the core in reset, releases it, pulses the core's req, then waits for done.
//  It measures the run length in cycles, flags runaway programs with a timeout,
//  and reports completion to the host or bench with a one-cycle pulse.

---
 rtl/core_run_pkg.sv | 35 +++
 rtl/run_cycle_ctr.sv | 36 +++
 rtl/core_run_ctrl.sv | 174 +++++++++++++++++
 tb/tb_core_run_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_run_pkg.sv
// core_run_pkg: shared types and default parameters for the host-side core run
// sequencer (core_run_ctrl and its cycle counter).
//  run_state_t      : sequencer state encoding
//  *_DEF            : default parameter values
//  holds_core_reset : states in which the processor is kept in reset
package core_run_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        REQ  = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } run_state_t;

    localparam int unsigned RST_CYC_DEF = 32'd2;
    localparam int unsigned CNT_W_DEF   = 32'd16;
    localparam int unsigned TMO_LIM_DEF = 32'd4095;
    localparam int unsigned ID_W_DEF    = 32'd8;

    // The core is only out of reset while it is being requested or running.
    function automatic logic holds_core_reset(input run_state_t s);
        logic r;
        case (s)
            IDLE:    r = 1'b1;
            RST:     r = 1'b1;
            REQ:     r = 1'b0;
            RUN:     r = 1'b0;
            DONE:    r = 1'b1;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/run_cycle_ctr.sv
// run_cycle_ctr: run-length cycle counter with clear, enable and limit flag.
//  clk, reset : clock, synchronous active-high reset
//  clr        : clear count to zero (wins over en)
//  en         : increment count by one
//  cnt        : current count (registered)
//  at_lim     : count equals TMO_LIM
module run_cycle_ctr
    import core_run_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TMO_LIM = TMO_LIM_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_lim
);

    // Count register; the controller never enables it at the limit, so it saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign at_lim = (cnt == CNT_W'(TMO_LIM));

endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: host-side run sequencer for the processor top level.
// Holds the core in reset, releases it, pulses req, waits for done, measures
// the run length, flags runaway runs and pulses finished at the end of a run.
//  clk, reset  : clock, synchronous active-high reset
//  start       : run request (sampled in IDLE only)
//  abort       : cancel, honoured in RST/REQ/RUN
//  core_done   : done from processor
//  core_reset  : reset to processor
//  core_req    : one-cycle request to processor
//  busy        : sequencer is not idle
//  finished    : one-cycle pulse at the end of a completed or timed-out run
//  timeout     : last run hit TMO_LIM (held until next start)
//  cycles      : cycle count of last/current run
//  run_cnt     : number of finished runs (wrapping)
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int unsigned RST_CYC = RST_CYC_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TMO_LIM = TMO_LIM_DEF,
    parameter int unsigned ID_W    = ID_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             core_done,
    output logic             core_reset,
    output logic             core_req,
    output logic             busy,
    output logic             finished,
    output logic             timeout,
    output logic [CNT_W-1:0] cycles,
    output logic [ID_W-1:0]  run_cnt
);

    localparam int unsigned RCW = (RST_CYC > 32'd1) ? $clog2(RST_CYC) : 32'd1;

    run_state_t     state_r;
    run_state_t     state_nxt_s;
    logic [RCW-1:0] rst_cnt_r;
    logic           launch_s;
    logic           cnt_en_s;
    logic           set_tmo_s;
    logic           at_lim_s;

    run_cycle_ctr #(
        .CNT_W   (CNT_W),
        .TMO_LIM (TMO_LIM)
    ) u_cycle_ctr (
        .clk    (clk),
        .reset  (reset),
        .clr    (launch_s),
        .en     (cnt_en_s),
        .cnt    (cycles),
        .at_lim (at_lim_s)
    );

    // Next-state logic; abort always wins, and done wins over the timeout.
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        cnt_en_s    = 1'b0;
        set_tmo_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt_s = RST;
                    launch_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RST: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (rst_cnt_r == '0) begin
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = RST;
                end
            end
            REQ: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                    cnt_en_s    = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (core_done) begin
                    state_nxt_s = DONE;
                end else if (at_lim_s) begin
                    state_nxt_s = DONE;
                    set_tmo_s   = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                    cnt_en_s    = 1'b1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Reset-hold countdown: loaded on launch, runs down while in RST.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt_r <= '0;
        end else if (launch_s) begin
            rst_cnt_r <= RCW'(RST_CYC - 32'd1);
        end else if ((state_r == RST) && (rst_cnt_r != '0)) begin
            rst_cnt_r <= rst_cnt_r - RCW'(1);
        end else begin
            rst_cnt_r <= rst_cnt_r;
        end
    end

    // Timeout flag: cleared by a new launch, set when RUN gives up at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout <= 1'b0;
        end else if (launch_s) begin
            timeout <= 1'b0;
        end else if (set_tmo_s) begin
            timeout <= 1'b1;
        end else begin
            timeout <= timeout;
        end
    end

    // Completed-run counter, bumped on the DONE cycle and wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (state_r == DONE) begin
            run_cnt <= run_cnt + ID_W'(1);
        end else begin
            run_cnt <= run_cnt;
        end
    end

    // Outputs registered from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset <= 1'b1;
            core_req   <= 1'b0;
            busy       <= 1'b0;
            finished   <= 1'b0;
        end else begin
            core_reset <= holds_core_reset(state_nxt_s);
            core_req   <= (state_nxt_s == REQ);
            busy       <= (state_nxt_s != IDLE);
            finished   <= (state_nxt_s == DONE);
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: self-checking bench for core_run_ctrl (RST_CYC=2, TMO_LIM=20).
// Expected run results are queued when a run is launched and popped by a
// monitor when the DUT pulses finished.
module tb_core_run_ctrl;

    localparam int unsigned RST_CYC = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TMO_LIM = 20;
    localparam int unsigned ID_W    = 8;

    typedef struct {
        logic [CNT_W-1:0] cyc;
        logic             tmo;
        logic [ID_W-1:0]  id;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             core_done = 1'b0;
    logic             core_reset;
    logic             core_req;
    logic             busy;
    logic             finished;
    logic             timeout;
    logic [CNT_W-1:0] cycles;
    logic [ID_W-1:0]  run_cnt;

    exp_t             sb[$];
    logic [ID_W-1:0]  model_id = '0;
    int               n_checks = 0;
    int               n_fail = 0;

    core_run_ctrl #(
        .RST_CYC (RST_CYC),
        .CNT_W   (CNT_W),
        .TMO_LIM (TMO_LIM),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .core_done  (core_done),
        .core_reset (core_reset),
        .core_req   (core_req),
        .busy       (busy),
        .finished   (finished),
        .timeout    (timeout),
        .cycles     (cycles),
        .run_cnt    (run_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Scoreboard monitor: checks every finished pulse against the queue.
    initial begin
        exp_t            e;
        logic            id_pend;
        logic [ID_W-1:0] exp_id;
        id_pend = 1'b0;
        exp_id  = '0;
        forever begin
            @(negedge clk);
            if (id_pend) begin
                id_pend = 1'b0;
                n_checks++;
                if (run_cnt !== exp_id) begin
                    n_fail++;
                    $display("FAIL run_cnt_after_done: got %0d expected %0d", run_cnt, exp_id);
                end
            end
            if (finished === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_finished: got finished=1 expected no pulse at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    n_checks++;
                    if (cycles !== e.cyc) begin
                        n_fail++;
                        $display("FAIL sb_cycles: got %0d expected %0d", cycles, e.cyc);
                    end
                    n_checks++;
                    if (timeout !== e.tmo) begin
                        n_fail++;
                        $display("FAIL sb_timeout: got %0b expected %0b", timeout, e.tmo);
                    end
                    id_pend = 1'b1;
                    exp_id  = e.id;
                end
            end
        end
    end

    // Launch with a start pulse and advance to RUN cycle k (cycles==k there).
    task automatic launch_to_run(input int k);
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (core_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        n_checks++;
        if (core_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_req: got core_req=%b expected 1 within 10 cycles", core_req);
        end
        step();
        for (int i = 1; i < k; i++) step();
    endtask

    // Full run with start pulse; core_done raised in RUN cycle done_cyc (0 = never).
    task automatic do_run(input int done_cyc);
        exp_t e;
        int   n;
        logic seen;
        e.tmo = (done_cyc == 0) || (done_cyc > int'(TMO_LIM));
        e.cyc = e.tmo ? CNT_W'(TMO_LIM) : CNT_W'(done_cyc);
        model_id = model_id + 1'b1;
        e.id = model_id;
        sb.push_back(e);
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_cleared_on_start: got %b expected 0", timeout);
        end
        n = 0;
        while (core_req !== 1'b1 && n < 10) begin
            if (core_reset === 1'b1 && busy === 1'b1) n++;
            step();
        end
        n_checks++;
        if (n != int'(RST_CYC) || core_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_hold_cycles: got %0d req=%b expected %0d req=1", n, core_req, RST_CYC);
        end
        n_checks++;
        if (core_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL req_core_reset: got %b expected 0", core_reset);
        end
        step();
        n_checks++;
        if (core_req !== 1'b0) begin
            n_fail++;
            $display("FAIL req_one_cycle: got %b expected 0", core_req);
        end
        seen = 1'b0;
        for (int j = 1; j <= 100 && !seen; j++) begin
            n_checks++;
            if (cycles !== CNT_W'(j)) begin
                n_fail++;
                $display("FAIL run_cycles: got %0d expected %0d", cycles, j);
            end
            if (j == done_cyc) core_done = 1'b1;
            step();
            core_done = 1'b0;
            if (finished === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL finished_seen: got none expected pulse within 100 cycles");
        end
        step();
        n_checks++;
        if (finished !== 1'b0 || busy !== 1'b0 || core_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL after_done: got fin=%b busy=%b crst=%b expected 0 0 1", finished, busy, core_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({core_reset, core_req, busy, finished, timeout} !== 5'b10000 || cycles !== '0 || run_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got crst=%b req=%b busy=%b fin=%b tmo=%b cyc=%0d id=%0d expected 1 0 0 0 0 0 0",
                     core_reset, core_req, busy, finished, timeout, cycles, run_cnt);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_normal();
        do_run(11);
    endtask

    task automatic test_reset_mid_run();
        launch_to_run(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_id = '0;
        n_checks++;
        if (busy !== 1'b0 || core_reset !== 1'b1 || cycles !== '0 || run_cnt !== '0 || finished !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b crst=%b cyc=%0d id=%0d fin=%b expected 0 1 0 0 0",
                     busy, core_reset, cycles, run_cnt, finished);
        end
        step();
        step();
    endtask

    task automatic test_timeout();
        do_run(0);
        n_checks++;
        if (timeout !== 1'b1 || cycles !== CNT_W'(TMO_LIM)) begin
            n_fail++;
            $display("FAIL timeout_held: got tmo=%b cyc=%0d expected 1 %0d", timeout, cycles, TMO_LIM);
        end
        do_run(4);
    endtask

    // Abort in RUN at cycles=5, then in RST and REQ.
    task automatic test_abort();
        logic [ID_W-1:0] id0;
        id0 = model_id;
        launch_to_run(5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || cycles !== CNT_W'(5) || run_cnt !== id0 || finished !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_run: got busy=%b cyc=%0d id=%0d fin=%b expected 0 5 %0d 0", busy, cycles, run_cnt, finished, id0);
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || core_reset !== 1'b1 || cycles !== '0) begin
            n_fail++;
            $display("FAIL abort_rst: got busy=%b crst=%b cyc=%0d expected 0 1 0", busy, core_reset, cycles);
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_checks++;
        if (core_req !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_req_reach: got req=%b expected 1", core_req);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || core_req !== 1'b0 || cycles !== '0 || run_cnt !== id0) begin
            n_fail++;
            $display("FAIL abort_req: got busy=%b req=%b cyc=%0d id=%0d expected 0 0 0 %0d", busy, core_req, cycles, run_cnt, id0);
        end
        step();
    endtask

    task automatic test_collisions();
        launch_to_run(3);
        core_done = 1'b1;
        abort = 1'b1;
        step();
        core_done = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || finished !== 1'b0 || cycles !== CNT_W'(3)) begin
            n_fail++;
            $display("FAIL done_vs_abort: got busy=%b fin=%b cyc=%0d expected 0 0 3", busy, finished, cycles);
        end
        step();
        do_run(int'(TMO_LIM));
        start = 1'b1;
        abort = 1'b1;
        step();
        step();
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || core_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL start_vs_abort: got busy=%b crst=%b expected 0 1", busy, core_reset);
        end
        step();
    endtask

    // 300 runs with start held; core_done high during RST/REQ and again at RUN cycle 3.
    task automatic test_back_to_back();
        exp_t            e;
        logic [ID_W-1:0] id_end;
        id_end = model_id + ID_W'(300);
        start = 1'b1;
        for (int r = 0; r < 300; r++) begin
            model_id = model_id + 1'b1;
            e.cyc = CNT_W'(3);
            e.tmo = 1'b0;
            e.id  = model_id;
            sb.push_back(e);
            step();
            core_done = 1'b1;
            n_checks++;
            if (busy !== 1'b1 || core_reset !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_relaunch: run %0d got busy=%b crst=%b expected 1 1", r, busy, core_reset);
            end
            step();
            step();
            n_checks++;
            if (core_req !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_req: run %0d got %b expected 1", r, core_req);
            end
            step();
            core_done = 1'b0;
            step();
            step();
            core_done = 1'b1;
            step();
            core_done = 1'b0;
            n_checks++;
            if (finished !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_finished: run %0d got %b expected 1", r, finished);
            end
            step();
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle_gap: run %0d got busy=%b expected 0", r, busy);
            end
            if (r == 299) start = 1'b0;
        end
        step();
        n_checks++;
        if (run_cnt !== id_end || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_wrap: got id=%0d busy=%b expected %0d 0", run_cnt, busy, id_end);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_normal();
        test_reset_mid_run();
        test_timeout();
        test_abort();
        test_collisions();
        test_back_to_back();
        step();
        step();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
